// File: rtl/instruction_fetch.sv
// Instruction fetch and sequencing unit: reads program bytes over req/ack, issues them to the
// ICU, computes the next pc (increment, skip, jump, return) and loads it into program_counter.
module instruction_fetch #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [15:0] RESET_ADDR  = 16'h0000
) (
    input  logic        fetch_clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [7:0]  instr,
    output logic        instr_valid,
    input  logic        icu_ready,
    input  logic        rr,
    output logic [15:0] addr_in,
    output logic        addr_w,
    output logic        stack_err
);
    localparam int unsigned   PtrW   = $clog2(STACK_DEPTH);
    localparam logic [PtrW:0] SpFull = (PtrW + 1)'(STACK_DEPTH);
    localparam logic [3:0]    OpJmp  = 4'hC;
    localparam logic [3:0]    OpRtn  = 4'hD;
    localparam logic [3:0]    OpSkz  = 4'hE;

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StJhi, StJlo, StUpdate} state_e;

    state_e        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   nxt_q, nxt_d;
    logic [7:0]    tgt_hi_q, tgt_hi_d;
    logic [7:0]    instr_q, instr_d;
    logic [PtrW:0] sp_q, sp_d;
    logic          err_q, err_d;
    logic [15:0]   stack_q [STACK_DEPTH];
    logic          push;
    logic [PtrW-1:0] top_idx;

    logic          mem_rd_q, mem_rd_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic          instr_valid_q, instr_valid_d;
    logic          addr_w_q, addr_w_d;
    logic [15:0]   addr_in_q, addr_in_d;

    assign top_idx = PtrW'(sp_q - (PtrW + 1)'(1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        nxt_d    = nxt_q;
        tgt_hi_d = tgt_hi_q;
        instr_d  = instr_q;
        sp_d     = sp_q;
        err_d    = err_q;
        push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fetch_en) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ack) begin
                    instr_d = mem_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (icu_ready) begin
                    state_d = StUpdate;
                    case (instr_q[7:4])
                        OpJmp: state_d = StJhi;
                        OpRtn: begin
                            if (sp_q != '0) begin
                                nxt_d = stack_q[top_idx];
                                sp_d  = sp_q - (PtrW + 1)'(1);
                            end else begin
                                nxt_d = RESET_ADDR;
                                err_d = 1'b1;
                            end
                        end
                        OpSkz:   nxt_d = rr ? pc_q + 16'd1 : pc_q + 16'd2;
                        default: nxt_d = pc_q + 16'd1;
                    endcase
                end
            end
            StJhi: begin
                if (mem_ack) begin
                    tgt_hi_d = mem_data;
                    state_d  = StJlo;
                end
            end
            StJlo: begin
                if (mem_ack) begin
                    nxt_d   = {tgt_hi_q, mem_data};
                    state_d = StUpdate;
                    // A full stack drops the return address and flags the error.
                    if (sp_q == SpFull) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + (PtrW + 1)'(1);
                    end
                end
            end
            StUpdate: begin
                pc_d    = nxt_q;
                state_d = fetch_en ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        mem_rd_d      = (state_d == StFetch) || (state_d == StJhi) || (state_d == StJlo);
        instr_valid_d = (state_d == StIssue);
        addr_w_d      = (state_d == StUpdate);
        addr_in_d     = (state_d == StUpdate) ? nxt_d : addr_in_q;
        case (state_d)
            StJhi:   mem_addr_d = pc_d + 16'd1;
            StJlo:   mem_addr_d = pc_d + 16'd2;
            default: mem_addr_d = pc_d;
        endcase
    end

    always_ff @(posedge fetch_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_ADDR;
            nxt_q         <= RESET_ADDR;
            tgt_hi_q      <= '0;
            instr_q       <= '0;
            sp_q          <= '0;
            err_q         <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= RESET_ADDR;
            instr_valid_q <= 1'b0;
            addr_w_q      <= 1'b0;
            addr_in_q     <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            nxt_q         <= nxt_d;
            tgt_hi_q      <= tgt_hi_d;
            instr_q       <= instr_d;
            sp_q          <= sp_d;
            err_q         <= err_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            addr_w_q      <= addr_w_d;
            addr_in_q     <= addr_in_d;
            if (push) stack_q[sp_q[PtrW-1:0]] <= pc_q + 16'd3;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_w      = addr_w_q;
    assign addr_in     = addr_in_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a memory model answers reads, and a scoreboard of
// expected (instruction, next address) pairs is checked at each issue handshake and load strobe.
module tb_instruction_fetch;
    localparam int unsigned STACK_DEPTH = 4;
    localparam logic [15:0] RESET_ADDR  = 16'h0000;

    logic        fetch_clk;
    logic        reset_n;
    logic        fetch_en;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        icu_ready;
    logic        rr;
    logic [15:0] addr_in;
    logic        addr_w;
    logic        stack_err;

    logic        ack_en;
    logic        stale_ack;
    logic [7:0]  mem [0:65535];

    typedef struct {
        logic [7:0]  instr;
        logic [15:0] nxt;
    } exp_t;
    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int w_prev      = 0;
    int w_period    = 0;

    instruction_fetch #(
        .STACK_DEPTH(STACK_DEPTH),
        .RESET_ADDR (RESET_ADDR)
    ) dut (
        .fetch_clk  (fetch_clk),
        .reset_n    (reset_n),
        .fetch_en   (fetch_en),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .icu_ready  (icu_ready),
        .rr         (rr),
        .addr_in    (addr_in),
        .addr_w     (addr_w),
        .stack_err  (stack_err)
    );

    initial begin
        fetch_clk = 1'b0;
        forever #5 fetch_clk = ~fetch_clk;
    end

    // Zero-wait-state memory; stale_ack injects an unsolicited acknowledge.
    assign mem_ack  = (mem_rd && ack_en) || stale_ack;
    assign mem_data = mem[mem_addr];

    always @(posedge fetch_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pending(input string tag);
        vectors++;
        assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s: observed unexpected DUT output expected none", tag);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected DUT event", tag);
    endtask

    task automatic expect_instr(input logic [7:0] i, input logic [15:0] n);
        exp_t e;
        e.instr = i;
        e.nxt   = n;
        exp_q.push_back(e);
    endtask

    always @(negedge fetch_clk) begin
        if (reset_n) begin
            if (instr_valid && icu_ready) begin
                check_pending("issue");
                if (exp_q.size() > 0) check("issue_instr", 32'(instr), 32'(exp_q[0].instr));
            end
            if (addr_w) begin
                check_pending("load");
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("addr_in", 32'(addr_in), 32'(e.nxt));
                end
                w_period = cyc - w_prev;
                w_prev   = cyc;
            end
        end
    end

    task automatic do_reset();
        @(posedge fetch_clk);
        #1;
        reset_n   = 1'b0;
        fetch_en  = 1'b0;
        icu_ready = 1'b1;
        rr        = 1'b1;
        ack_en    = 1'b1;
        stale_ack = 1'b0;
        repeat (2) @(negedge fetch_clk);
        reset_n = 1'b1;
    endtask

    // Let n instructions complete, dropping fetch_en in the last update so the DUT idles.
    task automatic run(input int n);
        int seen = 0;
        fetch_en = 1'b1;
        for (int c = 0; c < n * 20 + 40; c++) begin
            @(negedge fetch_clk);
            if (addr_w) begin
                seen++;
                if (seen == n) begin
                    fetch_en = 1'b0;
                    break;
                end
            end
        end
        if (seen != n) timeout("run");
        repeat (2) @(negedge fetch_clk);
    endtask

    task automatic wait_valid();
        bit got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge fetch_clk);
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("wait_valid");
    endtask

    task automatic wait_rd();
        bit got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge fetch_clk);
            if (mem_rd) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("wait_rd");
    endtask

    task automatic load3(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2);
        mem[a]         = b0;
        mem[a + 16'd1] = b1;
        mem[a + 16'd2] = b2;
    endtask

    initial begin
        reset_n   = 1'b0;
        fetch_en  = 1'b0;
        icu_ready = 1'b1;
        rr        = 1'b1;
        ack_en    = 1'b1;
        stale_ack = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Reset values, then a straight-line sequence at 3 cycles per instruction.
        do_reset();
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_addr_w", 32'(addr_w), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_addr_in", 32'(addr_in), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(RESET_ADDR));
        check("rst_stack_err", 32'(stack_err), 32'd0);
        load3(16'h0000, 8'h11, 8'h22, 8'h33);
        expect_instr(8'h11, 16'h0001);
        expect_instr(8'h22, 16'h0002);
        expect_instr(8'h33, 16'h0003);
        run(3);
        check("loop_period", 32'(w_period), 32'd3);
        check("addr_w_one_shot", 32'(addr_w), 32'd0);

        // ICU back-pressure holds the instruction.
        do_reset();
        icu_ready = 1'b0;
        fetch_en  = 1'b1;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", 32'(instr), 32'h11);
            check("stall_no_load", 32'(addr_w), 32'd0);
            @(negedge fetch_clk);
        end
        expect_instr(8'h11, 16'h0001);
        @(posedge fetch_clk);
        #1;
        icu_ready = 1'b1;
        run(1);

        // SKZ taken, not taken, and wrapping at the top of memory.
        mem[16'h0010] = 8'hE0;
        mem[16'h0011] = 8'h66;
        mem[16'h0012] = 8'h55;
        load3(16'h0000, 8'hC0, 8'h00, 8'h10);
        do_reset();
        rr = 1'b0;
        expect_instr(8'hC0, 16'h0010);
        expect_instr(8'hE0, 16'h0012);
        expect_instr(8'h55, 16'h0013);
        run(3);
        do_reset();
        expect_instr(8'hC0, 16'h0010);
        expect_instr(8'hE0, 16'h0011);
        expect_instr(8'h66, 16'h0012);
        run(3);
        load3(16'h0000, 8'hC0, 8'hFF, 8'hFF);
        mem[16'hFFFF] = 8'hE0;
        do_reset();
        rr = 1'b0;
        expect_instr(8'hC0, 16'hFFFF);
        expect_instr(8'hE0, 16'h0001);
        run(2);

        // JMP then RTN returns past the operand bytes.
        load3(16'h0000, 8'hC0, 8'h01, 8'h00);
        load3(16'h0100, 8'hC0, 8'h12, 8'h34);
        mem[16'h0103] = 8'h77;
        mem[16'h1234] = 8'hD0;
        do_reset();
        expect_instr(8'hC0, 16'h0100);
        expect_instr(8'hC0, 16'h1234);
        expect_instr(8'hD0, 16'h0103);
        expect_instr(8'h77, 16'h0104);
        run(4);
        check("jmp_rtn_no_err", 32'(stack_err), 32'd0);

        // RTN on an empty stack.
        mem[16'h0000] = 8'hD0;
        do_reset();
        expect_instr(8'hD0, RESET_ADDR);
        run(1);
        check("underflow_err", 32'(stack_err), 32'd1);

        // STACK_DEPTH+1 nested calls: the last push is dropped, earlier returns survive.
        load3(16'h0000, 8'hC0, 8'h00, 8'h10);
        load3(16'h0010, 8'hC0, 8'h00, 8'h20);
        load3(16'h0020, 8'hC0, 8'h00, 8'h30);
        load3(16'h0030, 8'hC0, 8'h00, 8'h40);
        load3(16'h0040, 8'hC0, 8'h00, 8'h50);
        mem[16'h0013] = 8'hD0;
        mem[16'h0023] = 8'hD0;
        mem[16'h0033] = 8'hD0;
        mem[16'h0050] = 8'hD0;
        do_reset();
        check("rst_clears_err", 32'(stack_err), 32'd0);
        expect_instr(8'hC0, 16'h0010);
        expect_instr(8'hC0, 16'h0020);
        expect_instr(8'hC0, 16'h0030);
        expect_instr(8'hC0, 16'h0040);
        run(4);
        check("full_no_err", 32'(stack_err), 32'd0);
        expect_instr(8'hC0, 16'h0050);
        expect_instr(8'hD0, 16'h0033);
        expect_instr(8'hD0, 16'h0023);
        expect_instr(8'hD0, 16'h0013);
        expect_instr(8'hD0, 16'h0003);
        run(5);
        check("overflow_err", 32'(stack_err), 32'd1);

        // Reset while a read is outstanding; a stale acknowledge afterwards is ignored.
        load3(16'h0000, 8'h11, 8'h22, 8'h33);
        do_reset();
        expect_instr(8'h11, 16'h0001);
        run(1);
        ack_en   = 1'b0;
        fetch_en = 1'b1;
        wait_rd();
        check("pending_addr", 32'(mem_addr), 32'h0001);
        #1;
        reset_n   = 1'b0;
        fetch_en  = 1'b0;
        stale_ack = 1'b1;
        #1;
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'(RESET_ADDR));
        repeat (2) @(negedge fetch_clk);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        repeat (2) @(negedge fetch_clk);
        check("stale_ack_ignored", 32'(instr_valid), 32'd0);
        stale_ack = 1'b0;
        expect_instr(8'h11, 16'h0001);
        run(1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
